univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 4, register width in bits; legal range WIDTH >= 2.
REQ-002 Parameter CNTW, default $clog2(WIDTH+1), shift-counter width; the integrator shall not override it.
REQ-003 clk  input  1  rising-edge clock; the block has a single clock domain.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 clr  input  1  synchronous clear of register and counter; lower priority than rst.
REQ-006 mode  input  3  operation select per REQ-012.
REQ-007 pi  input  WIDTH  parallel load data.
REQ-008 sin_lsb  input  1  serial bit entering at bit 0 on left shift.
REQ-009 sin_msb  input  1  serial bit entering at bit WIDTH-1 on right shift.
REQ-010 po  output  WIDTH  registered parallel output (register contents).
REQ-011 sout_msb / sout_lsb  output  1 each  = po[WIDTH-1] / po[0], combinational from the register.
REQ-011a cnt  output  CNTW  shifts since last load/clear, saturating at WIDTH.
REQ-011b done  output  1  registered one-cycle pulse on word-complete.

Function
REQ-012 Per rising clk, when rst=0 and clr=0, the register shall update by mode:
 000 HOLD: po unchanged; 001 LOAD: po<=pi; 010 SHL: po<={po[W-2:0],sin_lsb}; 011 SHR: po<={sin_msb,po[W-1:1]};
 100 ROTL: po<={po[W-2:0],po[W-1]}; 101 ROTR: po<={po[0],po[W-1:1]}; 110 ASR per REQ-024; 111 reserved, behaves as HOLD.
REQ-013 Latency: po reflects the operation one clock after mode/pi/sin_* are sampled; no combinational path from inputs to po.
REQ-014 Shift ops: SHL, SHR, ROTL, ROTR, and ASR when enabled.
REQ-015 cnt shall go to 0 on LOAD, clr or rst, increment by 1 on each shift op while cnt < WIDTH, and hold at WIDTH (saturate) on further shifts.
REQ-016 HOLD and reserved modes shall leave cnt unchanged.
REQ-017 done shall be 1 for exactly the cycle following the edge at which cnt goes from WIDTH-1 to WIDTH, and 0 otherwise.
REQ-018 A shift while cnt is already WIDTH shall not re-assert done.
REQ-019 LOAD in the same cycle cnt would saturate is impossible (single mode); a LOAD on the cycle done is high shall clear cnt to 0 and done to 0 at the next edge.
REQ-020 clr=1 shall force po=0, cnt=0, done=0 at the next edge regardless of mode.

Reset
REQ-021 rst=1 at a rising edge shall force po=0, cnt=0, done=0, overriding clr and mode.
REQ-022 Reset mid-shift sequence shall discard progress; after release the next shift op yields cnt=1.
REQ-023 While rst=1 across several edges, outputs shall remain at reset values.

Configuration
REQ-024 Macro UNIV_SHIFT_REG_ASR_EN defined: mode 110 = arithmetic shift right, po<={po[W-1],po[W-1:1]}, counted as a shift op; undefined: mode 110 behaves as HOLD, cnt unchanged, no ASR logic synthesised.

Verification (WIDTH=4)
REQ-025 rst=1 one edge, then mode=000 for 3 cycles -> po=0000, cnt=0, done=0 throughout.
REQ-026 LOAD pi=1011, then SHL with sin_lsb=1,0,0,1 -> po=0111,1110,1100,1001; cnt=1,2,3,4; done=1 only after the 4th shift; 5th SHL -> cnt stays 4, done=0.
REQ-027 LOAD pi=1001, ROTR x4 -> po=1100,0110,0011,1001 (original restored), done pulse after the 4th.
REQ-028 LOAD pi=1110, SHR with sin_msb=0 x2, then rst=1 -> po=0000, cnt=0; then SHR sin_msb=1 -> po=1000, cnt=1.
REQ-029 LOAD pi=1010, mode=110: with UNIV_SHIFT_REG_ASR_EN -> po=1101, cnt=1; without -> po=1010, cnt=0; mode=111 -> unchanged either way.
REQ-030 po=1111 with cnt=3, assert clr together with mode=SHL -> po=0000, cnt=0, done=0 at the next edge.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/load/shift/rotate (+ASR under UNIV_SHIFT_REG_ASR_EN), saturating shift count, word-done pulse.
// Latency: one clock from mode/pi/sin_* to po; no backpressure (accepts an operation every cycle).
module univ_shift_reg #(
  parameter int WIDTH = 4,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] pi,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  output logic [WIDTH-1:0] po,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CNTW-1:0]  cnt,
  output logic             done
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROTL = 3'b100;
  localparam logic [2:0] MODE_ROTR = 3'b101;
`ifdef UNIV_SHIFT_REG_ASR_EN
  localparam logic [2:0] MODE_ASR  = 3'b110;
`endif

  localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(WIDTH);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

  logic [WIDTH-1:0] po_nxt;
  logic             is_shift;

  always_comb begin
    po_nxt   = po;
    is_shift = 1'b0;
    case (mode)
      MODE_HOLD: po_nxt = po;
      MODE_LOAD: po_nxt = pi;
      MODE_SHL: begin
        po_nxt   = {po[WIDTH-2:0], sin_lsb};
        is_shift = 1'b1;
      end
      MODE_SHR: begin
        po_nxt   = {sin_msb, po[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      MODE_ROTL: begin
        po_nxt   = {po[WIDTH-2:0], po[WIDTH-1]};
        is_shift = 1'b1;
      end
      MODE_ROTR: begin
        po_nxt   = {po[0], po[WIDTH-1:1]};
        is_shift = 1'b1;
      end
`ifdef UNIV_SHIFT_REG_ASR_EN
      MODE_ASR: begin
        po_nxt   = {po[WIDTH-1], po[WIDTH-1:1]};
        is_shift = 1'b1;
      end
`endif
      default: po_nxt = po;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      po   <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      po <= po_nxt;
      if (mode == MODE_LOAD) begin
        cnt <= '0;
      end else if (is_shift && (cnt < CNT_MAX)) begin
        cnt <= cnt + 1'b1;
      end
      // Pulses only on the WIDTH-1 -> WIDTH transition, so saturated shifts stay quiet.
      done <= is_shift && (cnt == CNT_LAST);
    end
  end

  assign sout_msb = po[WIDTH-1];
  assign sout_lsb = po[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Randomized + directed bench for univ_shift_reg (WIDTH=4) against an arithmetic reference model.
module tb_univ_shift_reg;
  localparam int W    = 4;
  localparam int CW   = $clog2(W + 1);
  localparam int MODV = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic          clk = 1'b0;
  logic          rst, clr, sin_lsb, sin_msb;
  logic [2:0]    mode;
  logic [W-1:0]  pi;
  logic [W-1:0]  po;
  logic          sout_msb, sout_lsb, done;
  logic [CW-1:0] cnt;

  int n_checks = 0;
  int n_fail   = 0;

  int m_po   = 0;
  int m_cnt  = 0;
  int m_done = 0;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .mode(mode), .pi(pi),
    .sin_lsb(sin_lsb), .sin_msb(sin_msb), .po(po),
    .sout_msb(sout_msb), .sout_lsb(sout_lsb), .cnt(cnt), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: register held as an integer, operations as plain arithmetic.
  task automatic model_step(input bit r, input bit c, input int m, input int p,
                            input int sl, input int sm);
    int v;
    bit shifted;
    v = m_po;
    shifted = 1'b0;
    if (r || c) begin
      m_po = 0; m_cnt = 0; m_done = 0;
      return;
    end
    case (m)
      1: v = p;
      2: begin v = (m_po * 2 + sl) % MODV;               shifted = 1'b1; end
      3: begin v = m_po / 2 + sm * HALF;                 shifted = 1'b1; end
      4: begin v = (m_po * 2) % MODV + m_po / HALF;      shifted = 1'b1; end
      5: begin v = m_po / 2 + (m_po % 2) * HALF;         shifted = 1'b1; end
`ifdef UNIV_SHIFT_REG_ASR_EN
      6: begin v = m_po / 2 + (m_po / HALF) * HALF;      shifted = 1'b1; end
`endif
      default: v = m_po;
    endcase
    m_done = (shifted && m_cnt == W - 1) ? 1 : 0;
    if (m == 1) m_cnt = 0;
    else if (shifted && m_cnt < W) m_cnt = m_cnt + 1;
    m_po = v;
  endtask

  task automatic op(input bit r, input bit c, input logic [2:0] m,
                    input logic [W-1:0] p, input bit sl, input bit sm);
    rst = r; clr = c; mode = m; pi = p; sin_lsb = sl; sin_msb = sm;
    @(posedge clk);
    #1;
    model_step(r, c, int'(m), int'(p), int'(sl), int'(sm));
    check("po", po, m_po);
    check("cnt", cnt, m_cnt);
    check("done", done, m_done);
    check("sout_msb", sout_msb, (m_po / HALF) % 2);
    check("sout_lsb", sout_lsb, m_po % 2);
  endtask

  task automatic expect_state(input string tag, input int e_po, input int e_cnt, input int e_done);
    check({tag, "_po"}, po, e_po);
    check({tag, "_cnt"}, cnt, e_cnt);
    check({tag, "_done"}, done, e_done);
  endtask

  logic [W-1:0] shl_po  [4] = '{4'b0111, 4'b1110, 4'b1100, 4'b1001};
  logic         shl_sin [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [W-1:0] rotr_po [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};

  initial begin
    rst = 1'b0; clr = 1'b0; mode = 3'b000; pi = '0; sin_lsb = 1'b0; sin_msb = 1'b0;
    #2;

    // Reset then idle
    op(1, 0, 3'b000, 4'h0, 0, 0);
    expect_state("rst", 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      op(0, 0, 3'b000, 4'hF, 1, 1);
      expect_state("idle", 0, 0, 0);
    end

    // Load + left shifts, saturation
    op(0, 0, 3'b001, 4'b1011, 0, 0);
    expect_state("ld26", 4'b1011, 0, 0);
    for (int i = 0; i < 4; i++) begin
      op(0, 0, 3'b010, 4'h0, shl_sin[i], 0);
      expect_state("shl", shl_po[i], i + 1, (i == 3) ? 1 : 0);
    end
    op(0, 0, 3'b010, 4'h0, 0, 0);
    expect_state("shl_sat", 4'b0010, 4, 0);

    // Rotate right restores the word
    op(0, 0, 3'b001, 4'b1001, 0, 0);
    for (int i = 0; i < 4; i++) begin
      op(0, 0, 3'b101, 4'h0, 0, 0);
      expect_state("rotr", rotr_po[i], i + 1, (i == 3) ? 1 : 0);
    end
    // Load while done is high clears cnt and done
    op(0, 0, 3'b001, 4'b0101, 0, 0);
    expect_state("ld_on_done", 4'b0101, 0, 0);

    // Reset mid-sequence discards progress
    op(0, 0, 3'b001, 4'b1110, 0, 0);
    op(0, 0, 3'b011, 4'h0, 0, 0);
    op(0, 0, 3'b011, 4'h0, 0, 0);
    expect_state("shr2", 4'b0011, 2, 0);
    op(1, 1, 3'b010, 4'hF, 1, 1);
    expect_state("rst_mid", 0, 0, 0);
    op(1, 0, 3'b001, 4'hF, 1, 1);
    expect_state("rst_hold", 0, 0, 0);
    op(0, 0, 3'b011, 4'h0, 0, 1);
    expect_state("shr_after_rst", 4'b1000, 1, 0);

    // Mode 110 / 111
    op(0, 0, 3'b001, 4'b1010, 0, 0);
    op(0, 0, 3'b110, 4'h0, 0, 0);
`ifdef UNIV_SHIFT_REG_ASR_EN
    expect_state("asr", 4'b1101, 1, 0);
`else
    expect_state("asr_off", 4'b1010, 0, 0);
`endif
    op(0, 0, 3'b111, 4'h3, 1, 1);
`ifdef UNIV_SHIFT_REG_ASR_EN
    expect_state("rsvd", 4'b1101, 1, 0);
`else
    expect_state("rsvd", 4'b1010, 0, 0);
`endif

    // Clear overrides a shift
    op(0, 0, 3'b001, 4'b1111, 0, 0);
    for (int i = 0; i < 3; i++) op(0, 0, 3'b010, 4'h0, 1, 0);
    expect_state("pre_clr", 4'b1111, 3, 0);
    op(0, 1, 3'b010, 4'h0, 1, 0);
    expect_state("clr", 0, 0, 0);

    // Randomized operation stream against the model
    for (int i = 0; i < 2000; i++) begin
      op(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 3),
         3'($urandom_range(0, 7)), W'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
